// File: rtl/lsu_sequencer_if.sv
// Purpose : groups the core request/response handshake and the RAM port of lsu_sequencer.
// Ports   : req_* / resp_* (core side), ram_* (single-port synchronous RAM side).
// Modports: master = core + RAM environment, slave = the sequencer itself.
interface lsu_sequencer_if #(
    parameter int ADDRESS_WIDTH = 32
);
    // Core request
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_store;
    logic [2:0]               req_funct3;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [31:0]              req_store_value;
    // Core response
    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_efault;
    logic [31:0]              resp_load_value;
    // RAM port
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic                     ram_read_enable;
    logic                     ram_write_enable;
    logic [31:0]              ram_write_value;
    logic [31:0]              ram_read_value;

    modport master (
        output req_valid, req_store, req_funct3, req_address, req_store_value,
        output resp_ready, ram_read_value,
        input  req_ready, resp_valid, resp_efault, resp_load_value,
        input  ram_address, ram_read_enable, ram_write_enable, ram_write_value
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_address, req_store_value,
        input  resp_ready, ram_read_value,
        output req_ready, resp_valid, resp_efault, resp_load_value,
        output ram_address, ram_read_enable, ram_write_enable, ram_write_value
    );
endinterface

// File: rtl/lsu_sequencer.sv
// Purpose : load/store sequencer between core memory stage and a word-wide sync RAM (read, or read-modify-write).
// Latency : accept edge to first resp_valid cycle = 1 (fault), 3 (load), 4 (store).
// Backpr. : one request in flight; req_ready only in IDLE; response held stable until resp_ready.
// Ports   : clock/reset plain; everything else through lsu_sequencer_if.slave (req_*, resp_*, ram_*).

// Byte-lane helper: extracts/extends a load from a RAM word and merges a store into it.
module load_store32 (
    input  logic [2:0]  funct3_i,      // [1:0] size (byte/half/word), [2] unsigned
    input  logic [1:0]  offset_i,      // byte offset inside the word
    input  logic [31:0] ram_word_i,
    input  logic [31:0] store_value_i,
    output logic [31:0] load_value_o,
    output logic [31:0] merged_word_o
);
    logic [31:0] shifted;

    always_comb begin
        shifted = ram_word_i >> {offset_i, 3'b000};
        case (funct3_i[1:0])
            2'b00:   load_value_o = funct3_i[2] ? {24'b0, shifted[7:0]}
                                                : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_value_o = funct3_i[2] ? {16'b0, shifted[15:0]}
                                                : {{16{shifted[15]}}, shifted[15:0]};
            default: load_value_o = shifted;
        endcase
    end

    always_comb begin
        merged_word_o = ram_word_i;
        case (funct3_i[1:0])
            2'b00:   merged_word_o[{offset_i, 3'b000} +: 8]        = store_value_i[7:0];
            2'b01:   merged_word_o[{offset_i[1], 4'b0000} +: 16]   = store_value_i[15:0];
            default: merged_word_o = store_value_i;
        endcase
    end
endmodule

module lsu_sequencer #(
    parameter int ADDRESS_WIDTH = 32
) (
    input logic             clock,
    input logic             reset,
    lsu_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     store_q, store_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [1:0]               offset_q, offset_d;
    logic [31:0]              store_value_q, store_value_d;
    logic                     efault_q, efault_d;
    logic [31:0]              load_value_q, load_value_d;
    logic [ADDRESS_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [31:0]              write_value_q, write_value_d;

    logic                     accept_fault;
    logic [31:0]              extracted;
    logic [31:0]              merged;

    // Fault is decided from the live request so a bad access never touches RAM.
    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   accept_fault = 1'b0;
            2'b01:   accept_fault = bus.req_address[0];
            2'b10:   accept_fault = (bus.req_address[1:0] != 2'b00) || bus.req_funct3[2];
            default: accept_fault = 1'b1;
        endcase
        if (bus.req_store && bus.req_funct3[2]) begin
            accept_fault = 1'b1;
        end
    end

    load_store32 u_lanes (
        .funct3_i      (funct3_q),
        .offset_i      (offset_q),
        .ram_word_i    (bus.ram_read_value),
        .store_value_i (store_value_q),
        .load_value_o  (extracted),
        .merged_word_o (merged)
    );

    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        funct3_d      = funct3_q;
        offset_d      = offset_q;
        store_value_d = store_value_q;
        efault_d      = efault_q;
        load_value_d  = load_value_q;
        ram_address_d = ram_address_q;
        write_value_d = write_value_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d       = bus.req_store;
                    funct3_d      = bus.req_funct3;
                    offset_d      = bus.req_address[1:0];
                    store_value_d = bus.req_store_value;
                    efault_d      = accept_fault;
                    load_value_d  = '0;
                    if (accept_fault) begin
                        state_d = RESP;
                    end else begin
                        // RAM address only moves for real accesses; it holds otherwise.
                        ram_address_d = {bus.req_address[ADDRESS_WIDTH-1:2], 2'b00};
                        state_d       = READ;
                    end
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                // ram_read_value is valid in this cycle only.
                if (store_q) begin
                    write_value_d = merged;
                    state_d       = WRITE;
                end else begin
                    load_value_d = extracted;
                    state_d      = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            store_q       <= 1'b0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            store_value_q <= '0;
            efault_q      <= 1'b0;
            load_value_q  <= '0;
            ram_address_q <= '0;
            write_value_q <= '0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            funct3_q      <= funct3_d;
            offset_q      <= offset_d;
            store_value_q <= store_value_d;
            efault_q      <= efault_d;
            load_value_q  <= load_value_d;
            ram_address_q <= ram_address_d;
            write_value_q <= write_value_d;
        end
    end

    // Strobes decode straight from state, so reset kills them on the same edge.
    assign bus.req_ready        = (state_q == IDLE);
    assign bus.resp_valid       = (state_q == RESP);
    assign bus.resp_efault      = efault_q;
    assign bus.resp_load_value  = load_value_q;
    assign bus.ram_read_enable  = (state_q == READ);
    assign bus.ram_write_enable = (state_q == WRITE);
    assign bus.ram_address      = ram_address_q;
    assign bus.ram_write_value  = write_value_q;
endmodule

// File: tb/tb_lsu_sequencer.sv
module tb_lsu_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lsu_sequencer_if #(.ADDRESS_WIDTH(32)) bus ();
    lsu_sequencer #(.ADDRESS_WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int cyc_count = 0;
    int wr_count = 0;
    int rd_cycles[$];
    int acc_cycles[$];
    int resp_cycles[$];
    logic [31:0] ram_mem [0:255];
    logic [31:0] gold_mem [0:255];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = (32'h9e3779b9 * i) ^ (i << 7);
        if (i == 64) w = 32'h456789ab;
        return w;
    endfunction

    // Reference: what one request must produce, from size/offset arithmetic on the golden memory.
    function automatic void model_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] sv, output logic flt,
                                      output logic [31:0] lv, output logic [31:0] wv);
        int nbytes;
        int off;
        logic [31:0] w;
        logic [63:0] v;
        nbytes = 1 << f3[1:0];
        off = int'(a[1:0]);
        w = gold_mem[a[9:2]];
        flt = (nbytes == 8) || ((off % nbytes) != 0) || (st && f3[2]) || (!st && f3[2] && nbytes == 4);
        lv = 32'h0;
        wv = w;
        if (!flt) begin
            if (st) begin
                for (int i = 0; i < nbytes; i++) wv[8*(off+i) +: 8] = sv[8*i +: 8];
            end else begin
                v = ({32'h0, w} >> (8*off)) & ((64'd1 << (8*nbytes)) - 64'd1);
                if (!f3[2] && v >= (64'd1 << (8*nbytes-1))) v = v - (64'd1 << (8*nbytes));
                lv = v[31:0];
            end
        end
    endfunction

    // RAM environment: read data one cycle after the read strobe, write on the write strobe.
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
        bus.ram_read_value = 32'h0;
        forever begin
            @(posedge clock);
            if (bus.ram_read_enable === 1'b1) bus.ram_read_value <= ram_mem[bus.ram_address[9:2]];
            if (bus.ram_write_enable === 1'b1) ram_mem[bus.ram_address[9:2]] = bus.ram_write_value;
        end
    end

    // Compare process: model state advances once per cycle; outputs checked mid-cycle.
    initial begin
        logic m_busy, m_fault, m_store, chk_on;
        logic exp_rd, exp_wr, exp_resp;
        int m_cyc, m_resp_at;
        logic [31:0] m_lv, m_wv, m_waddr;
        m_busy = 0; m_fault = 0; m_store = 0; chk_on = 0;
        m_cyc = 0; m_resp_at = 1; m_lv = 0; m_wv = 0; m_waddr = 0;
        for (int i = 0; i < 256; i++) gold_mem[i] = init_word(i);
        forever begin
            @(negedge clock);
            cyc_count++;
            if (chk_on) begin
                exp_rd   = m_busy && !m_fault && m_cyc == 1;
                exp_wr   = m_busy && !m_fault && m_store && m_cyc == 3;
                exp_resp = m_busy && m_cyc >= m_resp_at;
                chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !m_busy});
                chk("ram_read_enable", {31'b0, bus.ram_read_enable}, {31'b0, exp_rd});
                chk("ram_write_enable", {31'b0, bus.ram_write_enable}, {31'b0, exp_wr});
                chk("resp_valid", {31'b0, bus.resp_valid}, {31'b0, exp_resp});
                if (exp_rd || exp_wr) chk("ram_address", bus.ram_address, m_waddr);
                if (exp_wr) begin
                    chk("ram_write_value", bus.ram_write_value, m_wv);
                    gold_mem[m_waddr[9:2]] = m_wv;
                end
                if (exp_resp) begin
                    chk("resp_efault", {31'b0, bus.resp_efault}, {31'b0, m_fault});
                    chk("resp_load_value", bus.resp_load_value, m_lv);
                end
                if (bus.ram_read_enable === 1'b1) rd_cycles.push_back(cyc_count);
                if (bus.ram_write_enable === 1'b1) wr_count++;
            end
            if (reset) begin
                m_busy = 0;
                chk_on = 1;
            end else if (!m_busy) begin
                if (bus.req_valid) begin
                    model_req(bus.req_store, bus.req_funct3, bus.req_address, bus.req_store_value,
                              m_fault, m_lv, m_wv);
                    m_store   = bus.req_store;
                    m_waddr   = {bus.req_address[31:2], 2'b00};
                    m_resp_at = m_fault ? 1 : (m_store ? 4 : 3);
                    m_busy    = 1;
                    m_cyc     = 1;
                    acc_cycles.push_back(cyc_count);
                end
            end else if (m_cyc >= m_resp_at && bus.resp_ready) begin
                m_busy = 0;
                resp_cycles.push_back(cyc_count);
            end else begin
                m_cyc++;
            end
        end
    end

    // Issues one request; returns at posedge+1 with the sequencer back in IDLE.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sv,
                          input int hold, output logic flt, output logic [31:0] lv, output int lat);
        int n;
        logic ok;
        bus.req_store = st; bus.req_funct3 = f3; bus.req_address = a; bus.req_store_value = sv;
        bus.req_valid = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clock); n++;
            if (bus.req_ready) ok = 1;
        end
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.req_store = 1'($urandom); bus.req_funct3 = 3'($urandom);
        bus.req_address = $urandom; bus.req_store_value = $urandom;
        bus.resp_ready = (hold == 0);
        ok = 0; lat = 0; flt = 1'bx; lv = 32'hx;
        while (!ok && lat < 20) begin
            @(negedge clock); lat++;
            if (bus.resp_valid) begin
                ok = 1; flt = bus.resp_efault; lv = bus.resp_load_value;
            end
        end
        if (!ok) chk("resp_timeout", 32'h0, 32'h1);
        if (hold > 0) begin
            repeat (hold) @(posedge clock);
            #1 bus.resp_ready = 1'b1;
        end
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'h1);
        chk({tag, "_resp_valid"}, {31'b0, bus.resp_valid}, 32'h0);
        chk({tag, "_resp_efault"}, {31'b0, bus.resp_efault}, 32'h0);
        chk({tag, "_resp_load_value"}, bus.resp_load_value, 32'h0);
        chk({tag, "_ram_strobes"}, {30'b0, bus.ram_read_enable, bus.ram_write_enable}, 32'h0);
        chk({tag, "_ram_address"}, bus.ram_address, 32'h0);
        chk({tag, "_ram_write_value"}, bus.ram_write_value, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic flt;
        logic [31:0] lv;
        int lat, wr_before, diffs;
        bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0;
        bus.req_address = 0; bus.req_store_value = 0; bus.resp_ready = 0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        chk_reset_values("reset");

        do_req(0, 3'b000, 32'h101, 0, 0, flt, lv, lat);
        chk("lb_lat", lat, 3); chk("lb_val", lv, 32'hffffff89); chk("lb_flt", {31'b0, flt}, 0);
        do_req(0, 3'b100, 32'h103, 0, 1, flt, lv, lat);
        chk("lbu_val", lv, 32'h00000045);
        do_req(1, 3'b001, 32'h102, 32'h0000beef, 0, flt, lv, lat);
        chk("sh_lat", lat, 4); chk("sh_ram", ram_mem[64], 32'hbeef89ab);
        do_req(0, 3'b010, 32'h100, 0, 0, flt, lv, lat);
        chk("lw_after_sh", lv, 32'hbeef89ab);
        do_req(1, 3'b010, 32'h100, 32'h456789ab, 0, flt, lv, lat);
        do_req(0, 3'b010, 32'h102, 0, 0, flt, lv, lat);
        chk("lw_mis_lat", lat, 1); chk("lw_mis_flt", {31'b0, flt}, 1); chk("lw_mis_val", lv, 0);
        do_req(1, 3'b100, 32'h100, 32'h12345678, 0, flt, lv, lat);
        chk("st_f3_100_flt", {31'b0, flt}, 1);
        do_req(0, 3'b011, 32'h100, 0, 2, flt, lv, lat);
        chk("f3_011_flt", {31'b0, flt}, 1);
        do_req(0, 3'b001, 32'h100, 0, 3, flt, lv, lat);
        chk("lh_hold_val", lv, 32'hffff89ab); chk("lh_hold_lat", lat, 3);

        // sb with reset in WAIT: the write must never happen.
        wr_before = wr_count;
        bus.req_store = 1; bus.req_funct3 = 3'b000; bus.req_address = 32'h100;
        bus.req_store_value = 32'h11; bus.req_valid = 1;
        @(posedge clock); #1 bus.req_valid = 0;
        @(posedge clock); #1 reset = 1;
        @(posedge clock); #1 reset = 0;
        chk_reset_values("midreset");
        repeat (4) @(posedge clock); #1;
        chk("midreset_no_write", wr_count, wr_before);
        chk("midreset_ram", ram_mem[64], 32'h456789ab);

        // Back-to-back loads with resp_ready tied high.
        rd_cycles.delete(); acc_cycles.delete(); resp_cycles.delete();
        bus.req_store = 0; bus.req_funct3 = 3'b010; bus.req_address = 32'h100;
        bus.req_valid = 1; bus.resp_ready = 1;
        repeat (10) @(posedge clock); #1 bus.req_valid = 0;
        repeat (6) @(posedge clock); #1 bus.resp_ready = 0;
        chk("b2b_enough", {31'b0, rd_cycles.size() >= 2 && acc_cycles.size() >= 2}, 32'h1);
        if (rd_cycles.size() >= 2) chk("b2b_rd_gap", rd_cycles[1] - rd_cycles[0], 4);
        if (acc_cycles.size() >= 2 && resp_cycles.size() >= 1)
            chk("b2b_accept_gap", acc_cycles[1] - resp_cycles[0], 1);

        for (int k = 0; k < 200; k++) begin
            do_req(1'($urandom), 3'($urandom_range(0, 7)), 32'h100 + $urandom_range(0, 255),
                   $urandom, $urandom_range(0, 2), flt, lv, lat);
        end

        diffs = 0;
        for (int i = 0; i < 256; i++) if (ram_mem[i] !== gold_mem[i]) diffs++;
        chk("final_ram_vs_model", diffs, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
